// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - multicycle control FSM (fetch/decode/execute/memory/writeback)
// Optional performance counters enabled by defining CTRL_PERF_CNT_EN.
module multi_cycle_controller #(
  parameter int OP_WIDTH       = 5,
  parameter int ALU_CTRL_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [OP_WIDTH-1:0]       opCode,
  input  logic                      zero,
  input  logic                      memReady,
  output logic                      pcEn,
  output logic                      irWrite,
  output logic                      iorD,
  output logic                      memRead,
  output logic                      memWrite,
  output logic                      regWrite,
  output logic                      regDst,
  output logic                      memToReg,
  output logic                      aluSrcA,
  output logic [1:0]                aluSrcB,
  output logic [1:0]                pcSrc,
  output logic [ALU_CTRL_WIDTH-1:0] aluControl,
  output logic                      illegalOp,
  output logic [3:0]                state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]               cycleCount,
  output logic [31:0]               instrCount
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SLT  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_LW   = 5'b10000;
  localparam logic [4:0] OP_SW   = 5'b10001;
  localparam logic [4:0] OP_BEQ  = 5'b11000;
  localparam logic [4:0] OP_J    = 5'b11100;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam int LOW_BITS = OP_WIDTH - 5;

  state_t     state_q;
  state_t     state_d;
  logic [4:0] op_hi;
  logic       low_zero;
  logic       is_rtype;
  logic       is_addi;
  logic       is_lw;
  logic       is_sw;
  logic       is_beq;
  logic       is_j;
  logic [3:0] rtype_alu;
  logic       pc_write;
  logic       branch;

  assign op_hi = opCode[OP_WIDTH-1 -: 5];

  // Wider opcodes only match when the bits below the 5-bit field are clear.
  generate
    if (LOW_BITS > 0) begin : g_low
      assign low_zero = ~|opCode[(LOW_BITS > 0 ? LOW_BITS-1 : 0):0];
    end else begin : g_nolow
      assign low_zero = 1'b1;
    end
  endgenerate

  always_comb begin
    is_rtype  = 1'b0;
    is_addi   = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_beq    = 1'b0;
    is_j      = 1'b0;
    rtype_alu = ALU_ADD;
    if (low_zero) begin
      case (op_hi)
        OP_ADD:  begin is_rtype = 1'b1; rtype_alu = ALU_ADD; end
        OP_SUB:  begin is_rtype = 1'b1; rtype_alu = ALU_SUB; end
        OP_AND:  begin is_rtype = 1'b1; rtype_alu = ALU_AND; end
        OP_OR:   begin is_rtype = 1'b1; rtype_alu = ALU_OR;  end
        OP_SLT:  begin is_rtype = 1'b1; rtype_alu = ALU_SLT; end
        OP_ADDI: is_addi = 1'b1;
        OP_LW:   is_lw   = 1'b1;
        OP_SW:   is_sw   = 1'b1;
        OP_BEQ:  is_beq  = 1'b1;
        OP_J:    is_j    = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    branch     = 1'b0;
    irWrite    = 1'b0;
    iorD       = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    regDst     = 1'b0;
    memToReg   = 1'b0;
    aluSrcA    = 1'b0;
    aluSrcB    = 2'b00;
    pcSrc      = 2'b00;
    aluControl = '0;
    illegalOp  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead    = 1'b1;
        aluSrcB    = 2'b01;
        aluControl = ALU_CTRL_WIDTH'(ALU_ADD);
        // The fetch handshake is suppressed while reset holds the FSM here.
        irWrite    = memReady & resetN;
        pc_write   = memReady & resetN;
        if (memReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB    = 2'b10;
        aluControl = ALU_CTRL_WIDTH'(ALU_ADD);
        if (is_rtype)            state_d = S_EXEC;
        else if (is_addi)        state_d = S_ADDIEX;
        else if (is_lw || is_sw) state_d = S_MEMADR;
        else if (is_beq)         state_d = S_BRANCH;
        else if (is_j)           state_d = S_JUMP;
        else begin
          state_d   = S_FETCH;
          illegalOp = 1'b1;
        end
      end
      S_MEMADR: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'b10;
        aluControl = ALU_CTRL_WIDTH'(ALU_ADD);
        state_d    = is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        if (memReady) state_d = S_FETCH;
      end
      S_EXEC: begin
        aluSrcA    = 1'b1;
        aluControl = ALU_CTRL_WIDTH'(rtype_alu);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'b10;
        aluControl = ALU_CTRL_WIDTH'(ALU_ADD);
        state_d    = S_ADDIWB;
      end
      S_ADDIWB: begin
        regWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA    = 1'b1;
        aluControl = ALU_CTRL_WIDTH'(ALU_SUB);
        pcSrc      = 2'b01;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcSrc    = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign pcEn  = pc_write | (branch & zero);
  assign state = state_q;

`ifdef CTRL_PERF_CNT_EN
  // An instruction retires whenever the FSM falls back into FETCH from elsewhere.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      cycleCount <= '0;
      instrCount <= '0;
    end else begin
      cycleCount <= cycleCount + 32'd1;
      if (state_q != S_FETCH && state_d == S_FETCH) begin
        instrCount <= instrCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb/tb_multi_cycle_controller.sv - self-checking bench for multi_cycle_controller
// Optional counter checks follow CTRL_PERF_CNT_EN.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [4:0] opCode = 5'b0;
  logic       zero = 1'b0;
  logic       memReady = 1'b0;
  logic       pcEn, irWrite, iorD, memRead, memWrite, regWrite, regDst, memToReg, aluSrcA;
  logic [1:0] aluSrcB, pcSrc;
  logic [3:0] aluControl;
  logic       illegalOp;
  logic [3:0] state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycleCount, instrCount;
`endif

  multi_cycle_controller #(.OP_WIDTH(5), .ALU_CTRL_WIDTH(4)) dut (
    .clk(clk), .resetN(resetN), .opCode(opCode), .zero(zero), .memReady(memReady),
    .pcEn(pcEn), .irWrite(irWrite), .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .pcSrc(pcSrc), .aluControl(aluControl), .illegalOp(illegalOp),
    .state(state)
`ifdef CTRL_PERF_CNT_EN
    , .cycleCount(cycleCount), .instrCount(instrCount)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: each instruction is a list of state codes walked in order.
  int          exp_state = 0;
  int          seq[$];
  int          pos = 0;
  int unsigned m_cyc = 0;
  int unsigned m_ret = 0;

  logic [3:0] seen_st[$];
  logic       seen_pcen[$], seen_irw[$], seen_rw[$], seen_rd[$], seen_mtr[$];
  logic       seen_mw[$], seen_mr[$], seen_ill[$];
  logic [1:0] seen_pcsrc[$];
  logic [3:0] seen_alu[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void build(input logic [4:0] op);
    seq = {};
    seq.push_back(0);
    seq.push_back(1);
    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100: begin seq.push_back(6); seq.push_back(7); end
      5'b01000: begin seq.push_back(8); seq.push_back(9); end
      5'b10000: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
      5'b10001: begin seq.push_back(2); seq.push_back(5); end
      5'b11000: seq.push_back(10);
      5'b11100: seq.push_back(11);
      default: ;
    endcase
  endfunction

  function automatic logic legal(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
      5'b01000, 5'b10000, 5'b10001, 5'b11000, 5'b11100: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] rtype_code(input logic [4:0] op);
    case (op)
      5'b00000: return 4'b0010;
      5'b00001: return 4'b0110;
      5'b00010: return 4'b0000;
      5'b00011: return 4'b0001;
      5'b00100: return 4'b0111;
      default:  return 4'b0000;
    endcase
  endfunction

  // {pcEn,irWrite,iorD,memRead,memWrite,regWrite,regDst,memToReg,aluSrcA,aluSrcB,pcSrc,aluControl,illegalOp}
  function automatic logic [17:0] exp_vec(input int st, input logic [4:0] op, input logic z,
                                          input logic mr, input logic rn);
    logic pe, irw, iod, mrd, mwr, rw, rd, mtr, sa, il;
    logic [1:0] sb, ps;
    logic [3:0] alu;
    {pe, irw, iod, mrd, mwr, rw, rd, mtr, sa, il} = '0;
    sb = 2'b00; ps = 2'b00; alu = 4'b0000;
    case (st)
      0:  begin mrd = 1; sb = 2'b01; alu = 4'b0010; irw = mr & rn; pe = mr & rn; end
      1:  begin sb = 2'b10; alu = 4'b0010; il = !legal(op); end
      2:  begin sa = 1; sb = 2'b10; alu = 4'b0010; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; mtr = 1; end
      5:  begin mwr = 1; iod = 1; end
      6:  begin sa = 1; alu = rtype_code(op); end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; sb = 2'b10; alu = 4'b0010; end
      9:  begin rw = 1; end
      10: begin sa = 1; alu = 4'b0110; ps = 2'b01; pe = z; end
      11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {pe, irw, iod, mrd, mwr, rw, rd, mtr, sa, sb, ps, alu, il};
  endfunction

  function automatic void advance(input logic rn, input logic mr);
    if (!rn) begin
      exp_state = 0; pos = 0; m_cyc = 0; m_ret = 0;
      return;
    end
    m_cyc++;
    if (exp_state == 0) begin
      if (mr) begin
        build(opCode);
        pos = 1;
        exp_state = seq[1];
      end
    end else if ((exp_state == 3 || exp_state == 5) && !mr) begin
      // waiting on memory
    end else begin
      pos++;
      if (pos >= seq.size()) begin
        exp_state = 0;
        m_ret++;
      end else begin
        exp_state = seq[pos];
      end
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("state", {28'd0, state}, exp_state);
      check("outputs",
            {14'd0, pcEn, irWrite, iorD, memRead, memWrite, regWrite, regDst, memToReg,
             aluSrcA, aluSrcB, pcSrc, aluControl, illegalOp},
            {14'd0, exp_vec(exp_state, opCode, zero, memReady, resetN)});
`ifdef CTRL_PERF_CNT_EN
      check("cycleCount", cycleCount, m_cyc);
      check("instrCount", instrCount, m_ret);
`endif
    end
  end

  task automatic clear_seen();
    seen_st = {}; seen_pcen = {}; seen_irw = {}; seen_rw = {}; seen_rd = {}; seen_mtr = {};
    seen_mw = {}; seen_mr = {}; seen_ill = {}; seen_pcsrc = {}; seen_alu = {};
  endtask

  task automatic step(input logic rn, input logic mr, input logic z);
    resetN = rn; memReady = mr; zero = z;
    @(negedge clk);
    seen_st.push_back(state);   seen_pcen.push_back(pcEn); seen_irw.push_back(irWrite);
    seen_rw.push_back(regWrite); seen_rd.push_back(regDst); seen_mtr.push_back(memToReg);
    seen_mw.push_back(memWrite); seen_mr.push_back(memRead); seen_ill.push_back(illegalOp);
    seen_pcsrc.push_back(pcSrc); seen_alu.push_back(aluControl);
    @(posedge clk);
    #1;
    advance(rn, mr);
  endtask

  task automatic run_lat(input logic [4:0] op, input logic z, input int exp_lat, input string name);
    int n;
    n = 0;
    clear_seen();
    opCode = op;
    do begin
      step(1'b1, 1'b1, z);
      n++;
    end while (state != 4'd0 && n < 20);
    check({name, "_latency"}, n, exp_lat);
  endtask

  initial begin
    logic [4:0] ops[10];
    int lw_states[9];
    int lw_mr[9];
    int ill_cnt, wr_cnt;
    ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
            5'b01000, 5'b10000, 5'b10001, 5'b11000, 5'b11100};
    lw_states = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    lw_mr = '{1, 1, 1, 0, 0, 0, 1, 1, 0};

    // reset for two cycles with memReady high
    step(1'b0, 1'b1, 1'b0);
    chk_en = 1'b1;
    clear_seen();
    step(1'b0, 1'b1, 1'b0);
    check("reset_state", {28'd0, state}, 0);
    check("reset_memRead", {31'd0, memRead}, 1);
    check("reset_irWrite_in_reset", {31'd0, seen_irw[0]}, 0);
    check("reset_pcEn_in_reset", {31'd0, seen_pcen[0]}, 0);

    // LW with three stall cycles in MEMRD, beginning at reset release
    clear_seen();
    opCode = 5'b10000;
    for (int i = 0; i < 9; i++) step(1'b1, lw_mr[i][0], 1'b0);
    check("release_irWrite", {31'd0, seen_irw[0]}, 1);
    check("release_pcEn", {31'd0, seen_pcen[0]}, 1);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("lw_state_%0d", i), {28'd0, seen_st[i]}, lw_states[i]);
      check($sformatf("lw_regWrite_%0d", i), {31'd0, seen_rw[i] & seen_mtr[i]}, (i == 7) ? 1 : 0);
    end

    // BEQ taken then not taken
    run_lat(5'b11000, 1'b1, 3, "beq_taken");
    check("beq_taken_pcEn", {31'd0, seen_pcen[2]}, 1);
    check("beq_pcSrc", {30'd0, seen_pcsrc[2]}, 1);
    run_lat(5'b11000, 1'b0, 3, "beq_not_taken");
    check("beq_not_taken_pcEn", {31'd0, seen_pcen[2]}, 0);

    // R-type ALU codes and writeback
    run_lat(5'b00001, 1'b0, 4, "sub");
    check("sub_alu", {28'd0, seen_alu[2]}, 32'h6);
    check("sub_wb_regWrite", {31'd0, seen_rw[3]}, 1);
    check("sub_wb_regDst", {31'd0, seen_rd[3]}, 1);
    run_lat(5'b00100, 1'b0, 4, "slt");
    check("slt_alu", {28'd0, seen_alu[2]}, 32'h7);
    run_lat(5'b01000, 1'b0, 4, "addi");
    run_lat(5'b10000, 1'b0, 5, "lw");
    run_lat(5'b10001, 1'b0, 4, "sw");
    run_lat(5'b11100, 1'b0, 3, "j");

    // undefined opcode
    run_lat(5'b10101, 1'b0, 2, "illegal");
    ill_cnt = 0; wr_cnt = 0;
    foreach (seen_ill[i]) begin
      ill_cnt += int'(seen_ill[i]);
      wr_cnt  += int'(seen_rw[i]) + int'(seen_mw[i]);
    end
    check("illegal_pulses", ill_cnt, 1);
    check("illegal_decode_state", {28'd0, seen_st[1]}, 1);
    check("illegal_writes", wr_cnt, 0);

    // SW stalled in MEMWR, then reset
    opCode = 5'b10001;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("sw_stall_state", {28'd0, state}, 5);
    check("sw_stall_memWrite", {31'd0, memWrite}, 1);
    step(1'b0, 1'b0, 1'b0);
    check("sw_reset_state", {28'd0, state}, 0);
    check("sw_reset_memWrite", {31'd0, memWrite}, 0);
    check("sw_reset_memRead", {31'd0, memRead}, 1);
    check("sw_reset_iorD", {31'd0, iorD}, 0);
`ifdef CTRL_PERF_CNT_EN
    check("cnt_reset_cycle", cycleCount, 0);
    check("cnt_reset_instr", instrCount, 0);
`endif
    run_lat(5'b00000, 1'b0, 4, "add");
    run_lat(5'b11100, 1'b0, 3, "j2");
    run_lat(5'b11000, 1'b1, 3, "beq2");
`ifdef CTRL_PERF_CNT_EN
    check("cnt_instr_3", instrCount, 3);
    check("cnt_cycle_10", cycleCount, 10);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (exp_state == 0) begin
        r = $urandom_range(0, 11);
        if (r < 10) opCode = ops[r];
        else opCode = 5'($urandom_range(0, 31));
      end
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
